// File: rtl/counter_chk_pkg.sv
// counter_chk_pkg: shared FSM state type and default widths for the counter checker
package counter_chk_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAIL} chk_state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_ERR_W = 8;
endpackage

// File: rtl/counter_chk_satcnt.sv
// counter_chk_satcnt: saturating tally, an increment in the same cycle as a clear yields 1
module counter_chk_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_inc) r_cnt <= i_clr ? W'(1) : (&r_cnt ? r_cnt : r_cnt + W'(1));
    else if (i_clr) r_cnt <= '0;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/counter_checker.sv
// counter_checker: up/down counter observer; COUNTER_CHK_WRAP_EN adds wrap_up_cnt/wrap_dn_cnt tallies
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ERR_W    = DEF_ERR_W,
  parameter int STOP_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_rst,
  input  logic             mon_mode,
  input  logic [WIDTH-1:0] mon_count,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] exp_count,
  output logic             valid,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
`ifdef COUNTER_CHK_WRAP_EN
  output logic [ERR_W-1:0] wrap_up_cnt,
  output logic [ERR_W-1:0] wrap_dn_cnt,
`endif
  output logic             fail
);
  chk_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_s_count, r_exp, w_pred;
  logic             r_s_mode, r_s_rst, r_err, w_track, w_mis;
  always_ff @(posedge clk) begin
    r_s_count <= mon_count;
    r_s_mode  <= mon_mode;
    r_s_rst   <= mon_rst;
  end
  assign w_pred  = r_s_rst ? '0 : (r_s_mode ? r_s_count + WIDTH'(1) : r_s_count - WIDTH'(1));
  assign w_track = r_state == TRACK;
  assign w_mis   = w_track && (mon_count != w_pred);
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE  ? SYNC :
             r_state == SYNC  ? TRACK :
             r_state == TRACK ? (w_mis ? ((STOP_ERR != 0) ? FAIL : SYNC) : TRACK) :
             FAIL;
  always_comb begin
    valid = w_track;
    fail  = r_state == FAIL;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_err <= 1'b0;
      r_exp <= '0;
    end else begin
      r_err <= w_mis;
      if (w_track) r_exp <= w_pred;
    end
  assign err       = r_err;
  assign exp_count = w_track ? w_pred : r_exp;
  counter_chk_satcnt #(.W(ERR_W)) u_err_cnt (
    .clk(clk), .rst(rst), .i_inc(w_mis), .i_clr(clr_stats), .o_cnt(err_cnt)
  );
`ifdef COUNTER_CHK_WRAP_EN
  logic w_ok;
  assign w_ok = w_track && !w_mis && !r_s_rst;
  counter_chk_satcnt #(.W(ERR_W)) u_wrap_up (
    .clk(clk), .rst(rst), .i_inc(w_ok && r_s_mode && (&r_s_count)),
    .i_clr(clr_stats), .o_cnt(wrap_up_cnt)
  );
  counter_chk_satcnt #(.W(ERR_W)) u_wrap_dn (
    .clk(clk), .rst(rst), .i_inc(w_ok && !r_s_mode && (r_s_count == '0)),
    .i_clr(clr_stats), .o_cnt(wrap_dn_cnt)
  );
`endif
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed checks of two checker instances (STOP_ERR=0 and STOP_ERR=1)
module tb_counter_checker;
  logic       clk = 1'b0;
  logic       rst, mon_rst, mon_mode, clr_stats;
  logic [3:0] mon_count;
  logic [1:0] valid, err, fail;
  logic [3:0] expc [2];
  logic [7:0] errc [2];
`ifdef COUNTER_CHK_WRAP_EN
  logic [7:0] wup [2];
  logic [7:0] wdn [2];
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    counter_checker #(.WIDTH(4), .ERR_W(8), .STOP_ERR(g)) dut (
      .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_mode(mon_mode),
      .mon_count(mon_count), .clr_stats(clr_stats), .exp_count(expc[g]),
      .valid(valid[g]), .err(err[g]), .err_cnt(errc[g]),
`ifdef COUNTER_CHK_WRAP_EN
      .wrap_up_cnt(wup[g]), .wrap_dn_cnt(wdn[g]),
`endif
      .fail(fail[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic cyc(input logic r, input logic mr, input logic md, input logic [3:0] c, input logic cl);
    rst = r;
    mon_rst = mr;
    mon_mode = md;
    mon_count = c;
    clr_stats = cl;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
  endtask
  initial begin
    do_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst valid%0d", k), valid[k], 0);
      check($sformatf("rst err%0d", k), err[k], 0);
      check($sformatf("rst fail%0d", k), fail[k], 0);
      check($sformatf("rst err_cnt%0d", k), errc[k], 0);
      check($sformatf("rst exp%0d", k), expc[k], 0);
    end
    for (int i = 0; i < 18; i++) begin
      cyc(0, 0, 1, 4'(i), 0);
      check($sformatf("up valid i=%0d", i), valid[0], (i >= 1) ? 1 : 0);
      check($sformatf("up err i=%0d", i), err[0], 0);
      if (i >= 1) check($sformatf("up exp i=%0d", i), expc[0], (i + 1) % 16);
    end
    check("up err_cnt0", errc[0], 0);
    check("up err_cnt1", errc[1], 0);
`ifdef COUNTER_CHK_WRAP_EN
    check("up wrap_up", wup[0], 1);
    check("up wrap_dn", wdn[0], 0);
`endif
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 4'(i), 0);
    cyc(0, 0, 1, 9, 0);
    check("mis err0", err[0], 1);
    check("mis err1", err[1], 1);
    check("mis err_cnt0", errc[0], 1);
    check("mis err_cnt1", errc[1], 1);
    check("mis valid0", valid[0], 0);
    check("mis valid1", valid[1], 0);
    check("mis fail0", fail[0], 0);
    check("mis fail1", fail[1], 1);
    check("mis hold exp0", expc[0], 6);
    cyc(0, 0, 1, 10, 0);
    check("resync err0", err[0], 0);
    check("resync valid0", valid[0], 1);
    check("resync exp0", expc[0], 11);
    check("sticky err1", err[1], 0);
    check("sticky valid1", valid[1], 0);
    check("sticky fail1", fail[1], 1);
    check("sticky exp1", expc[1], 6);
    cyc(0, 0, 1, 11, 0);
    cyc(0, 0, 1, 12, 0);
    check("resync track err0", err[0], 0);
    check("resync track valid0", valid[0], 1);
    check("sticky fail1 later", fail[1], 1);
    do_reset();
    check("rst clears fail1", fail[1], 0);
    check("rst clears err_cnt1", errc[1], 0);
    check("rst clears err_cnt0", errc[0], 0);
    cyc(0, 0, 0, 2, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("dn exp wrap", expc[0], 15);
    check("dn err a", err[0], 0);
    cyc(0, 0, 0, 15, 0);
    check("dn err b", err[0], 0);
    cyc(0, 0, 0, 14, 0);
    check("dn err c", err[0], 0);
    check("dn exp", expc[0], 13);
`ifdef COUNTER_CHK_WRAP_EN
    check("dn wrap_dn", wdn[0], 1);
    check("dn wrap_up", wup[0], 0);
    cyc(0, 0, 0, 13, 1);
    check("clr wrap_dn", wdn[0], 0);
`endif
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'(i), 0);
    cyc(0, 1, 1, 4, 0);
    check("mrst err a", err[0], 0);
    check("mrst exp", expc[0], 0);
    cyc(0, 0, 1, 0, 0);
    check("mrst err b", err[0], 0);
    check("mrst exp after", expc[0], 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 2, 0);
    check("mrst err c", err[0], 0);
    cyc(0, 0, 1, 7, 0);
    check("mrst held err", err[0], 1);
    check("mrst held err_cnt", errc[0], 1);
    do_reset();
    for (int n = 1; n <= 620; n++) begin
      cyc(0, 0, 1, 0, 0);
      if (n == 22) check("sat mid err_cnt0", errc[0], 10);
    end
    check("sat err_cnt0", errc[0], 255);
    check("sat err_cnt1", errc[1], 1);
    check("sat fail1", fail[1], 1);
    cyc(0, 0, 1, 0, 1);
    check("clr+mis err0", err[0], 1);
    check("clr+mis err_cnt0", errc[0], 1);
    check("clr err_cnt1", errc[1], 0);
    cyc(0, 0, 1, 0, 1);
    check("clr err_cnt0", errc[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
